// File: rtl/piso_if.sv
// Parallel-load / serial-status bundle of the piso serialiser: word handshake,
// shift and output enables, and framing status. The serial line itself is a plain port.
interface piso_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             ie;
    logic             oe;
    logic             frame;
    logic             done;
    logic             busy;

    modport master (
        output din, load_valid, ie, oe,
        input  load_ready, frame, done, busy
    );

    modport slave (
        input  din, load_valid, ie, oe,
        output load_ready, frame, done, busy
    );
endinterface

// File: rtl/piso.sv
// Parallel-in serial-out shifter with a one-word hold buffer so that back-to-back
// words stream with no gap bit; q is tri-stated by oe.
module piso #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    piso_if.slave bus,
    output wire   q
);
    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic [CNT_W-1:0] cnt_q;

    logic accept;
    logic last_bit;
    logic q_bit;

    function automatic logic [WIDTH-1:0] shift_fn(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
        else           return {1'b0, v[WIDTH-1:1]};
    endfunction

    function automatic logic head_fn(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) return v[WIDTH-1];
        else           return v[0];
    endfunction

    assign bus.load_ready = !hold_full_q && !rst;
    assign accept         = bus.load_valid && bus.load_ready;
    assign last_bit       = (state_q == SHIFT) && bus.ie && (cnt_q == LAST);

    assign bus.done  = last_bit;
    assign bus.frame = (state_q == SHIFT);
    assign bus.busy  = (state_q == SHIFT) || hold_full_q;

    // The line idles low when enabled; oe gates only this driver.
    assign q_bit = (state_q == SHIFT) ? head_fn(sh_q) : 1'b0;
    assign q     = bus.oe ? q_bit : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sh_q    <= bus.din;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A word arriving on the last-bit cycle bypasses the hold buffer.
                    if (accept && !last_bit) begin
                        hold_q      <= bus.din;
                        hold_full_q <= 1'b1;
                    end
                    if (last_bit) begin
                        if (hold_full_q) begin
                            sh_q        <= hold_q;
                            hold_full_q <= 1'b0;
                            cnt_q       <= '0;
                        end else if (accept) begin
                            sh_q  <= bus.din;
                            cnt_q <= '0;
                        end else begin
                            sh_q    <= shift_fn(sh_q);
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end
                    end else if (bus.ie) begin
                        sh_q  <= shift_fn(sh_q);
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_piso.sv
// Directed bench for piso: an MSB-first and an LSB-first instance share stimulus;
// pull-ups on the serial lines make a released (Z) line read as 1.
module tb_piso;
    logic clk;
    logic rst;
    wire  q_m;
    wire  q_l;

    pullup (q_m);
    pullup (q_l);

    piso_if #(.WIDTH(8)) bm ();
    piso_if #(.WIDTH(8)) bl ();

    piso #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bm.slave), .q(q_m));
    piso #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bl.slave), .q(q_l));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       lv;
        logic [7:0] din;
        logic       ie;
        logic       oe;
        logic       qm;
        logic       ql;
        logic       fr;
        logic       dn;
        logic       bs;
        logic       rd;
    } vec_t;

    vec_t vt[$];
    int   total = 0;
    int   bad   = 0;

    logic [7:0] w1 = 8'hB2;
    logic [7:0] w2 = 8'h3C;
    logic [7:0] w3 = 8'h5A;

    task automatic add(input logic lv, input logic [7:0] d, input logic ie, input logic oe,
                       input logic qm, input logic ql, input logic fr, input logic dn,
                       input logic bs, input logic rd);
        vec_t v;
        v.lv = lv; v.din = d; v.ie = ie; v.oe = oe;
        v.qm = qm; v.ql = ql; v.fr = fr; v.dn = dn; v.bs = bs; v.rd = rd;
        vt.push_back(v);
    endtask

    task automatic drive(input logic lv, input logic [7:0] d, input logic ie, input logic oe);
        bm.load_valid = lv; bm.din = d; bm.ie = ie; bm.oe = oe;
        bl.load_valid = lv; bl.din = d; bl.ie = ie; bl.oe = oe;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic qm, input logic ql, input logic fr,
                           input logic dn, input logic bs, input logic rd);
        chk({nm, "_qm"}, 32'(q_m), 32'(qm));
        chk({nm, "_ql"}, 32'(q_l), 32'(ql));
        chk({nm, "_frame"}, 32'(bm.frame), 32'(fr));
        chk({nm, "_done"}, 32'(bm.done), 32'(dn));
        chk({nm, "_done_l"}, 32'(bl.done), 32'(dn));
        chk({nm, "_busy"}, 32'(bm.busy), 32'(bs));
        chk({nm, "_ready"}, 32'(bm.load_ready), 32'(rd));
    endtask

    // Drive one cycle's inputs, check at the falling edge, then advance past the rising edge.
    task automatic cyc(input string nm, input logic lv, input logic [7:0] d, input logic ie,
                       input logic oe, input logic qm, input logic ql, input logic fr,
                       input logic dn, input logic bs, input logic rd);
        drive(lv, d, ie, oe);
        @(negedge clk);
        chk_all(nm, qm, ql, fr, dn, bs, rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single word, then two words streamed through the hold buffer.
        add(1, w1, 1, 1, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) add(0, 8'h00, 1, 1, w1[7-k], w1[k], 1, k == 7, 1, 1);
        add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1);
        add(1, w1, 1, 1, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++)
            add(k == 1, (k == 1) ? w2 : 8'h00, 1, 1, w1[7-k], w1[k], 1, k == 7, 1, k <= 1);
        for (int k = 0; k < 8; k++) add(0, 8'h00, 1, 1, w2[7-k], w2[k], 1, k == 7, 1, 1);
        add(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1);

        rst = 1'b1;
        drive(0, 8'h00, 1, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ready", 32'(bm.load_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all("after_rst", 0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;

        for (int i = 0; i < vt.size(); i++)
            cyc($sformatf("vec%0d", i), vt[i].lv, vt[i].din, vt[i].ie, vt[i].oe,
                vt[i].qm, vt[i].ql, vt[i].fr, vt[i].dn, vt[i].bs, vt[i].rd);

        // New word offered exactly on the last-bit cycle loads straight into the shifter.
        cyc("dir_n", 1, w1, 1, 1, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++)
            cyc($sformatf("dir_a%0d", k), k == 7, (k == 7) ? w2 : 8'h00, 1, 1,
                w1[7-k], w1[k], 1, k == 7, 1, 1);
        for (int k = 0; k < 8; k++)
            cyc($sformatf("dir_b%0d", k), 0, 8'h00, 1, 1, w2[7-k], w2[k], 1, k == 7, 1, 1);
        cyc("dir_end", 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1);

        // ie alternating 0,1: every bit is presented for two cycles.
        cyc("ie_n", 1, w1, 1, 1, 0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 16; k++)
            cyc($sformatf("ie_%0d", k), 0, 8'h00, (k % 2) == 0, 1,
                w1[7-((k-1)/2)], w1[(k-1)/2], 1, k == 16, 1, 1);
        cyc("ie_end", 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1);

        // oe low for N+2..N+5: line released while shifting continues.
        cyc("oe_n", 1, w1, 1, 1, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            if (k >= 1 && k <= 4)
                cyc($sformatf("oe_%0d", k + 1), 0, 8'h00, 1, 0, 1, 1, 1, 0, 1, 1);
            else
                cyc($sformatf("oe_%0d", k + 1), 0, 8'h00, 1, 1,
                    w1[7-k], w1[k], 1, k == 7, 1, 1);
        end
        cyc("oe_end", 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1);

        // Reset with a word shifting and another held, then a clean restart.
        cyc("rs_n", 1, w1, 1, 1, 0, 0, 0, 0, 0, 1);
        cyc("rs_1", 0, 8'h00, 1, 1, w1[7], w1[0], 1, 0, 1, 1);
        cyc("rs_2", 1, w2, 1, 1, w1[6], w1[1], 1, 0, 1, 1);
        cyc("rs_3", 0, 8'h00, 1, 1, w1[5], w1[2], 1, 0, 1, 0);
        rst = 1'b1;
        drive(1, w3, 1, 1);
        @(negedge clk);
        chk("rs_4_ready", 32'(bm.load_ready), 32'd0);
        chk("rs_4_done", 32'(bm.done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc("rs_5", 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1);
        cyc("rs_6", 1, w3, 1, 1, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++)
            cyc($sformatf("rs_w%0d", k), 0, 8'h00, 1, 1, w3[7-k], w3[k], 1, k == 7, 1, 1);
        cyc("rs_end", 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/piso.md
PISO -- requirements
Module: piso

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: parallel word width; legal range WIDTH >= 2.
REQ-002 SHALL provide parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 first on the line, 0 = bit 0 first.
REQ-003 SHALL provide port clk, input, 1: clock; all state on rising edge.
REQ-004 SHALL provide port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL provide port din, input, WIDTH: parallel word to serialise.
REQ-006 SHALL provide port load_valid, input, 1: din holds a word to accept.
REQ-007 SHALL provide port load_ready, output, 1: a word is accepted on any cycle with load_valid && load_ready.
REQ-008 SHALL provide port ie, input, 1: shift enable; the line advances one bit per cycle with ie=1.
REQ-009 SHALL provide port oe, input, 1: output enable for q.
REQ-010 SHALL provide port q, output, 1: serial data; high-impedance when oe=0.
REQ-011 SHALL provide port frame, output, 1: high while q carries a valid data bit.
REQ-012 SHALL provide port done, output, 1: one-cycle pulse marking consumption of a word's last bit.
REQ-013 SHALL provide port busy, output, 1: high while a word is shifting or held pending.

Function
REQ-014 SHALL contain a WIDTH-bit shift register, a one-word hold buffer with a full flag, and a bit counter of clog2(WIDTH) bits.
REQ-015 SHALL implement states IDLE and SHIFT; frame = (state == SHIFT); busy = SHIFT or hold full.
REQ-016 SHALL drive load_ready = !hold_full && !rst.
REQ-017 An accept in IDLE SHALL load din into the shift register, clear the counter, and enter SHIFT next cycle; the first bit appears on q the cycle after accept.
REQ-018 An accept in SHIFT SHALL write din into the hold buffer and set hold_full; the shifting word is undisturbed.
REQ-019 In SHIFT, q SHALL present sh[WIDTH-1] (MSB_FIRST=1) or sh[0] (MSB_FIRST=0); each ie=1 cycle consumes the presented bit, shifts one place toward the output end, and increments the counter.
REQ-020 With ie=0, shift register, counter and state SHALL hold; accepts per REQ-017/018 still occur.
REQ-021 done SHALL be combinational: state == SHIFT && ie && counter == WIDTH-1.
REQ-022 On a done cycle with hold_full=1, the hold word SHALL move to the shift register, hold_full SHALL clear, counter SHALL clear, state SHALL stay SHIFT; no gap bit.
REQ-023 On a done cycle with hold_full=0 and an accept, din SHALL load directly into the shift register, with hold untouched and state staying SHIFT.
REQ-024 On a done cycle with hold_full=0 and no accept, state SHALL return to IDLE.
REQ-025 In IDLE with oe=1, q SHALL drive 0.
REQ-026 oe SHALL affect only the q driver; internal shifting, frame, done, busy are independent of oe.

Reset
REQ-027 rst SHALL override ie, oe and load_valid and complete in one cycle.
REQ-028 After reset: state IDLE, shift register 0, hold 0, hold_full 0, counter 0, frame 0, busy 0, done 0, load_ready 1, q 0 when oe=1.
REQ-029 Reset mid-word SHALL abandon the current word and any held word, with no done pulse.

Verification
REQ-030 MSB_FIRST=1, ie=1, oe=1, accept 8'hB2 in IDLE at cycle N -> q = 1,0,1,1,0,0,1,0 on N+1..N+8; frame high N+1..N+8; done only at N+8; IDLE at N+9.
REQ-031 MSB_FIRST=0, same stimulus -> q = 0,1,0,0,1,1,0,1 on N+1..N+8.
REQ-032 Accept 8'hB2 at N, then 8'h3C at N+2 -> load_ready low N+3..N+8; 16 contiguous bits 10110010 00111100; done at N+8 and N+16; frame never drops.
REQ-033 8'hB2 with ie toggling 1,0,1,0,... -> each bit held two cycles; done once, on the 8th ie=1 cycle; frame high 16 cycles.
REQ-034 oe=0 from N+2 to N+5 while shifting 8'hB2 -> q = Z on those cycles; q = 0 at N+6 (bit 6); done still at N+8.
REQ-035 rst asserted at N+4 with hold full -> at N+5 frame=0, busy=0, load_ready=1, q=0; no done; the next accept serialises cleanly.
